// File: rtl/nd_display_scanner_if.sv
// Signal bundle between the DG0045 display outputs, the scanner and the 7-segment drive.
// The master side supplies the core strobe, the core nibble and the controls; the slave side is the scanner.
interface nd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [3:0]            nL;
    logic                  ND;
    logic                  clear;
    logic                  lz_blank;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_en;
    logic [7:0]            cap_count;

    modport master (
        output nL, ND, clear, lz_blank,
        input  seg, dig_en, cap_count
    );

    modport slave (
        input  nL, ND, clear, lz_blank,
        output seg, dig_en, cap_count
    );
endinterface

// File: rtl/nd_display_scanner.sv
// Captures the nibble on ~nL at the end of each qualified ND low pulse into a shift register of digits,
// and time-multiplexes those digits onto a common-cathode 7-segment display.
module nd_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int MIN_LOW    = 2,
    parameter int SCAN_DIV   = 1024,
    parameter int BLANK_CLKS = 16
) (
    input  logic                 clk,
    input  logic                 RESET,
    nd_display_scanner_if.slave  bus
);
    localparam int LW = $clog2(MIN_LOW + 1);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    // Strobe synchronizer and the matching nibble delay line.
    logic            s1_reg, s2_reg, s3_reg;
    logic [3:0]      n1_reg, n2_reg;
    logic [LW-1:0]   low_cnt_reg;

    logic [3:0]      digit_reg [NUM_DIGITS];
    logic [7:0]      cap_count_reg;

    logic [CW-1:0]   scan_cnt_reg;
    logic [IW-1:0]   scan_idx_reg;
    logic [6:0]      seg_reg;
    logic [NUM_DIGITS-1:0] dig_en_reg;

    logic            qual_rise;
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] blank_digit;
    logic [NUM_DIGITS-1:0] slot_hot;
    logic [3:0]      cur_digit;
    logic            in_blank;
    logic            scan_wrap;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Sync flops idle high so releasing reset never looks like the end of a pulse.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            s1_reg      <= 1'b1;
            s2_reg      <= 1'b1;
            s3_reg      <= 1'b1;
            n1_reg      <= 4'hF;
            n2_reg      <= 4'hF;
            low_cnt_reg <= '0;
        end else begin
            s1_reg <= bus.ND;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
            n1_reg <= bus.nL;
            n2_reg <= n1_reg;
            if (s2_reg) begin
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != LW'(MIN_LOW)) begin
                low_cnt_reg <= low_cnt_reg + 1'b1;
            end
        end
    end

    assign qual_rise = s2_reg && !s3_reg && (low_cnt_reg == LW'(MIN_LOW));

    // clear takes priority over a capture landing in the same cycle.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= 4'h0;
            end
            cap_count_reg <= 8'h00;
        end else if (bus.clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= 4'h0;
            end
            cap_count_reg <= 8'h00;
        end else if (qual_rise) begin
            digit_reg[0] <= ~n2_reg;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= digit_reg[i-1];
            end
            cap_count_reg <= cap_count_reg + 8'h01;
        end
    end

    assign scan_wrap = (scan_cnt_reg == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= '0;
        end else if (scan_wrap) begin
            scan_cnt_reg <= '0;
            if (scan_idx_reg == IW'(NUM_DIGITS - 1)) begin
                scan_idx_reg <= '0;
            end else begin
                scan_idx_reg <= scan_idx_reg + 1'b1;
            end
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_zero[gi] = (digit_reg[gi] == 4'h0);
            assign slot_hot[gi]   = (scan_idx_reg == IW'(gi));
            if (gi == 0) begin : g_first
                assign blank_digit[gi] = 1'b0;
            end else begin : g_upper
                assign blank_digit[gi] = bus.lz_blank && (&digit_zero[NUM_DIGITS-1:gi]);
            end
        end
    endgenerate

    assign cur_digit = digit_reg[scan_idx_reg];
    assign in_blank  = (scan_cnt_reg < CW'(BLANK_CLKS));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            seg_reg    <= 7'h00;
            dig_en_reg <= '0;
        end else if (in_blank) begin
            seg_reg    <= 7'h00;
            dig_en_reg <= '0;
        end else begin
            dig_en_reg <= slot_hot;
            seg_reg    <= blank_digit[scan_idx_reg] ? 7'h00 : hex7(cur_digit);
        end
    end

    assign bus.seg       = seg_reg;
    assign bus.dig_en    = dig_en_reg;
    assign bus.cap_count = cap_count_reg;
endmodule

// File: tb/tb_nd_display_scanner.sv
// Bench for nd_display_scanner: a cycle reference model checks every output each clock,
// a table of pulse records checks capture counts and displayed digits, plus reset/lz/wrap sequences.
module tb_nd_display_scanner;
    localparam int N       = 4;
    localparam int MIN_LOW = 2;
    localparam int SD      = 64;
    localparam int BLANK   = 16;

    logic clk   = 1'b0;
    logic RESET = 1'b0;

    nd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

    nd_display_scanner #(
        .NUM_DIGITS (N),
        .MIN_LOW    (MIN_LOW),
        .SCAN_DIV   (SD),
        .BLANK_CLKS (BLANK)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset release, digit values, capture count,
    // current ND low run length and captures due at a future edge.
    int         t;
    int         m_dig [N];
    int         m_cap;
    int         run;
    int         pend_edge [$];
    int         pend_nib  [$];
    logic [6:0] exp_seg;
    logic [N-1:0] exp_dig;
    logic [3:0] cur_nl;
    logic       cur_lz;

    typedef struct {
        logic [3:0]  nib;
        int          len;
        bit          clr;
        logic [7:0]  exp_cap;
        logic [15:0] exp_digits;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [6:0] hex7(input int d);
        case (d)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t   = 0;
        m_cap = 0;
        run = 0;
        for (int j = 0; j < N; j++) m_dig[j] = 0;
        pend_edge.delete();
        pend_nib.delete();
    endtask

    // One clock edge of the reference model; outputs reflect state from before this edge.
    task automatic model_edge(input logic nd, input logic [3:0] nl, input logic clr, input logic lz);
        int c;
        int idx;
        int nb;
        bit blank;
        logic [3:0] inv;
        t++;
        c   = (t - 1) % SD;
        idx = ((t - 1) / SD) % N;
        exp_dig = '0;
        exp_seg = 7'h00;
        if (c >= BLANK) begin
            exp_dig[idx] = 1'b1;
            blank = lz && (idx != 0);
            for (int j = idx; j < N; j++) if (m_dig[j] != 0) blank = 1'b0;
            exp_seg = blank ? 7'h00 : hex7(m_dig[idx]);
        end
        if (pend_edge.size() > 0 && pend_edge[0] == t) begin
            void'(pend_edge.pop_front());
            nb = pend_nib.pop_front();
            if (!clr) begin
                for (int j = N - 1; j > 0; j--) m_dig[j] = m_dig[j-1];
                m_dig[0] = nb;
                m_cap = (m_cap + 1) % 256;
            end
        end
        if (clr) begin
            for (int j = 0; j < N; j++) m_dig[j] = 0;
            m_cap = 0;
        end
        if (!nd) begin
            run++;
        end else begin
            if (run >= MIN_LOW) begin
                inv = ~nl;
                pend_edge.push_back(t + 2);
                pend_nib.push_back(int'(inv));
            end
            run = 0;
        end
    endtask

    task automatic step(input logic nd, input logic [3:0] nl, input logic clr, input logic lz);
        bus.ND       = nd;
        bus.nL       = nl;
        bus.clear    = clr;
        bus.lz_blank = lz;
        @(posedge clk);
        model_edge(nd, nl, clr, lz);
        #1;
        chk("seg", 32'(bus.seg), 32'(exp_seg));
        chk("dig_en", 32'(bus.dig_en), 32'(exp_dig));
        chk("cap_count", 32'(bus.cap_count), 32'(m_cap));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, cur_nl, 1'b0, cur_lz);
    endtask

    // ND low for len cycles, then high; clr_rise lands clear on the edge the capture is due.
    task automatic pulse(input logic [3:0] nib, input int len, input bit clr_rise);
        cur_nl = ~nib;
        repeat (len) step(1'b0, cur_nl, 1'b0, cur_lz);
        step(1'b1, cur_nl, 1'b0, cur_lz);
        step(1'b1, cur_nl, 1'b0, cur_lz);
        step(1'b1, cur_nl, clr_rise, cur_lz);
        step(1'b1, cur_nl, 1'b0, cur_lz);
        step(1'b1, cur_nl, 1'b0, cur_lz);
    endtask

    // Runs one full rotation and checks each slot mid-way against digits given as {d3,d2,d1,d0}.
    task automatic check_rot(input logic [15:0] ed, input logic lz);
        int c;
        int idx;
        bit blank;
        logic [3:0] d;
        logic [15:0] upper;
        logic [N-1:0] hot;
        repeat (N * SD) begin
            step(1'b1, cur_nl, 1'b0, lz);
            c   = (t - 1) % SD;
            idx = ((t - 1) / SD) % N;
            if (c == SD / 2) begin
                d     = ed[idx*4 +: 4];
                upper = ed >> (idx * 4);
                blank = lz && (idx != 0) && (upper == 16'h0000);
                hot   = '0;
                hot[idx] = 1'b1;
                chk($sformatf("slot%0d_seg", idx), 32'(bus.seg), 32'(blank ? 7'h00 : hex7(int'(d))));
                chk($sformatf("slot%0d_dig_en", idx), 32'(bus.dig_en), 32'(hot));
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #1;
        model_reset();
        chk("reset_seg", 32'(bus.seg), 32'h0);
        chk("reset_dig_en", 32'(bus.dig_en), 32'h0);
        chk("reset_cap_count", 32'(bus.cap_count), 32'h0);
        repeat (2) @(negedge clk);
        RESET = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'h5, 2, 1'b0, 8'd1, 16'h0005};
        tbl[1]  = '{4'h0, 1, 1'b0, 8'd1, 16'h0005};
        tbl[2]  = '{4'h7, 2, 1'b1, 8'd0, 16'h0000};
        tbl[3]  = '{4'h1, 2, 1'b0, 8'd1, 16'h0001};
        tbl[4]  = '{4'h2, 4, 1'b0, 8'd2, 16'h0012};
        tbl[5]  = '{4'h3, 2, 1'b0, 8'd3, 16'h0123};
        tbl[6]  = '{4'h4, 3, 1'b0, 8'd4, 16'h1234};
        tbl[7]  = '{4'h9, 2, 1'b0, 8'd5, 16'h2349};
        tbl[8]  = '{4'hE, 2, 1'b1, 8'd0, 16'h0000};
        tbl[9]  = '{4'h7, 2, 1'b0, 8'd1, 16'h0007};
        tbl[10] = '{4'h3, 2, 1'b0, 8'd2, 16'h0073};

        cur_nl       = 4'hF;
        cur_lz       = 1'b0;
        bus.ND       = 1'b1;
        bus.nL       = 4'hF;
        bus.clear    = 1'b0;
        bus.lz_blank = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle scan: rotation order, blanking window, zeros shown as 3F, wrap back to slot 0.
        check_rot(16'h0000, 1'b0);
        idle(SD);

        for (int i = 0; i < 11; i++) begin
            pulse(tbl[i].nib, tbl[i].len, tbl[i].clr);
            chk($sformatf("tbl%0d_cap", i), 32'(bus.cap_count), 32'(tbl[i].exp_cap));
            check_rot(tbl[i].exp_digits, 1'b0);
        end

        // Leading-zero suppression on digits 0,0,7,3.
        check_rot(16'h0073, 1'b1);
        check_rot(16'h0073, 1'b0);

        // Reset while ND is low; ND then rises with no fresh low pulse.
        repeat (3) step(1'b0, cur_nl, 1'b0, 1'b0);
        do_reset();
        idle(8);
        chk("no_capture_after_reset", 32'(bus.cap_count), 32'h0);
        check_rot(16'h0000, 1'b0);

        // Randomized pulses, lengths, clears and lz_blank against the model.
        for (int i = 0; i < 80; i++) begin
            cur_lz = 1'($urandom_range(0, 1));
            pulse(4'($urandom_range(0, 15)), int'($urandom_range(1, 4)), ($urandom_range(0, 7) == 0));
            idle(int'($urandom_range(0, 3)));
        end

        // cap_count wraps 255 -> 0.
        step(1'b1, cur_nl, 1'b1, cur_lz);
        for (int i = 0; i < 256; i++) pulse(4'($urandom_range(0, 15)), 2, 1'b0);
        chk("cap_wrap", 32'(bus.cap_count), 32'h0);
        pulse(4'h6, 2, 1'b0);
        chk("cap_after_wrap", 32'(bus.cap_count), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
